datapath_pipe: RTL and testbench

- Parametrised successor to the two-register datapath.
- Contains an NREG-entry register file with an external write port, two independent read ports and a 3-bit mode-select ALU, all feeding a 2-stage pipeline.
- ALU results can be written back into the register file. Dependent operations see fresh data through a forwarding path.
- Registered status flags and nibble display taps are provided for the board display logic.

---
 rtl/datapath_pipe.sv | 144 ++++++++++++++
 tb/tb_datapath_pipe.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/datapath_pipe.sv
// Register file + mode-select ALU feeding a 2-stage issue/execute pipeline with writeback and forwarding.
// Latency 2 edges from issue to ALU_out, one op per cycle, no stalls (there is no backpressure input).
module datapath_pipe #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int AW     = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WE,
  input  logic [AW-1:0]     WADDR,
  input  logic [DATA_W-1:0] Din,
  input  logic              OP_VALID,
  input  logic [AW-1:0]     RA,
  input  logic [AW-1:0]     RB,
  input  logic [2:0]        MS,
  input  logic              WB_EN,
  input  logic [AW-1:0]     WB_ADDR,
  output logic [DATA_W-1:0] ALU_out,
  output logic              OUT_VALID,
  output logic [3:0]        FLAGS,
  output logic [3:0]        Dis_1,
  output logic [3:0]        Dis_2
);

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_NOT = 3'b101,
    ALU_SHL = 3'b110,
    ALU_SHR = 3'b111
  } alu_op_e;

  logic [DATA_W-1:0] rf [NREG];

  logic              s1_vld;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  alu_op_e           s1_ms;
  logic              s1_wb_en;
  logic [AW-1:0]     s1_wb_addr;

  logic [DATA_W-1:0] alu_res;
  logic              alu_c;
  logic              alu_v;
  logic              alu_n;
  logic              alu_z;
  logic [DATA_W:0]   sum_ext;
  logic [DATA_W:0]   diff_ext;

  logic              wb_act;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;

  assign sum_ext  = {1'b0, s1_a} + {1'b0, s1_b};
  assign diff_ext = {1'b0, s1_a} - {1'b0, s1_b};

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (s1_ms)
      ALU_ADD: begin
        alu_res = sum_ext[DATA_W-1:0];
        alu_c   = sum_ext[DATA_W];
        alu_v   = (s1_a[DATA_W-1] == s1_b[DATA_W-1]) && (alu_res[DATA_W-1] != s1_a[DATA_W-1]);
      end
      ALU_SUB: begin
        // Top bit of the widened difference is the unsigned borrow (A < B).
        alu_res = diff_ext[DATA_W-1:0];
        alu_c   = diff_ext[DATA_W];
        alu_v   = (s1_a[DATA_W-1] != s1_b[DATA_W-1]) && (alu_res[DATA_W-1] != s1_a[DATA_W-1]);
      end
      ALU_AND: alu_res = s1_a & s1_b;
      ALU_OR:  alu_res = s1_a | s1_b;
      ALU_XOR: alu_res = s1_a ^ s1_b;
      ALU_NOT: alu_res = ~s1_a;
      ALU_SHL: alu_res = s1_a << s1_b[3:0];
      ALU_SHR: alu_res = s1_a >> s1_b[3:0];
      default: alu_res = '0;
    endcase
  end

  assign alu_n  = alu_res[DATA_W-1];
  assign alu_z  = (alu_res == '0);
  assign wb_act = s1_vld && s1_wb_en;

  // Executing op's result beats a same-cycle external write, matching the write-collision rule.
  assign op_a = (wb_act && (s1_wb_addr == RA)) ? alu_res :
                (WE && (WADDR == RA))          ? Din     : rf[RA];
  assign op_b = (wb_act && (s1_wb_addr == RB)) ? alu_res :
                (WE && (WADDR == RB))          ? Din     : rf[RB];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else begin
      if (WE) begin
        rf[WADDR] <= Din;
      end
      if (wb_act) begin
        rf[s1_wb_addr] <= alu_res;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_vld     <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_ms      <= ALU_ADD;
      s1_wb_en   <= 1'b0;
      s1_wb_addr <= '0;
      Dis_1      <= '0;
      Dis_2      <= '0;
      ALU_out    <= '0;
      FLAGS      <= '0;
      OUT_VALID  <= 1'b0;
    end else begin
      s1_vld <= OP_VALID;
      if (OP_VALID) begin
        s1_a       <= op_a;
        s1_b       <= op_b;
        s1_ms      <= alu_op_e'(MS);
        s1_wb_en   <= WB_EN;
        s1_wb_addr <= WB_ADDR;
        Dis_1      <= op_a[3:0];
        Dis_2      <= op_b[3:0];
      end
      OUT_VALID <= s1_vld;
      if (s1_vld) begin
        ALU_out <= alu_res;
        FLAGS   <= {alu_n, alu_v, alu_c, alu_z};
      end
    end
  end

endmodule

// File: tb/tb_datapath_pipe.sv
// Directed-vector bench for datapath_pipe with hand-computed expectations.
module tb_datapath_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] din;
  logic        op_valid;
  logic [2:0]  ra;
  logic [2:0]  rb;
  logic [2:0]  ms;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] alu_out;
  logic        out_valid;
  logic [3:0]  flags;
  logic [3:0]  dis_1;
  logic [3:0]  dis_2;

  int n_tests = 0;
  int n_fail  = 0;

  datapath_pipe #(.DATA_W(16), .NREG(8), .AW(3)) dut (
    .CLK(clk), .RST(rst), .WE(we), .WADDR(waddr), .Din(din),
    .OP_VALID(op_valid), .RA(ra), .RB(rb), .MS(ms),
    .WB_EN(wb_en), .WB_ADDR(wb_addr),
    .ALU_out(alu_out), .OUT_VALID(out_valid), .FLAGS(flags),
    .Dis_1(dis_1), .Dis_2(dis_2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle 1 time unit after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    we = 1'b1; waddr = a; din = d;
    cyc();
    we = 1'b0;
  endtask

  task automatic issue(input logic [2:0] a, input logic [2:0] b, input logic [2:0] m,
                       input logic wbe, input logic [2:0] wba);
    op_valid = 1'b1; ra = a; rb = b; ms = m; wb_en = wbe; wb_addr = wba;
  endtask

  typedef struct {
    logic [2:0]  m;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [3:0]  fl;
  } vec_t;

  vec_t vecs [12];

  initial begin
    vecs[0]  = '{3'b000, 16'h7FFF, 16'h0001, 16'h8000, 4'b1100};
    vecs[1]  = '{3'b001, 16'h0000, 16'h0001, 16'hFFFF, 4'b1010};
    vecs[2]  = '{3'b000, 16'hFFFF, 16'h0001, 16'h0000, 4'b0011};
    vecs[3]  = '{3'b010, 16'hF0F0, 16'h0F33, 16'h0030, 4'b0000};
    vecs[4]  = '{3'b011, 16'hF0F0, 16'h0F33, 16'hFFF3, 4'b1000};
    vecs[5]  = '{3'b100, 16'hF0F0, 16'h0F33, 16'hFFC3, 4'b1000};
    vecs[6]  = '{3'b101, 16'hF0F0, 16'h0F33, 16'h0F0F, 4'b0000};
    vecs[7]  = '{3'b110, 16'hF0F0, 16'h0F33, 16'h8780, 4'b1000};
    vecs[8]  = '{3'b111, 16'hF0F0, 16'h0F33, 16'h1E1E, 4'b0000};
    vecs[9]  = '{3'b001, 16'h8000, 16'h0001, 16'h7FFF, 4'b0100};
    vecs[10] = '{3'b001, 16'h0005, 16'h0005, 16'h0000, 4'b0001};
    vecs[11] = '{3'b110, 16'h1234, 16'h0010, 16'h1234, 4'b0000};

    rst = 1'b1; we = 1'b0; waddr = '0; din = '0;
    op_valid = 1'b0; ra = '0; rb = '0; ms = '0; wb_en = 1'b0; wb_addr = '0;
    cyc(); cyc();
    rst = 1'b0;
    cyc(); cyc(); cyc();
    check("reset_alu_out", alu_out, 0);
    check("reset_flags", flags, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_dis_1", dis_1, 0);
    check("reset_dis_2", dis_2, 0);

    // Basic ADD with writeback to r3
    wr(3'd1, 16'h0005);
    wr(3'd2, 16'h0003);
    issue(3'd1, 3'd2, 3'b000, 1'b1, 3'd3);
    cyc();
    op_valid = 1'b0;
    check("add_dis_1", dis_1, 4'h5);
    check("add_dis_2", dis_2, 4'h3);
    check("add_not_yet_valid", out_valid, 0);
    cyc();
    check("add_valid", out_valid, 1);
    check("add_result", alu_out, 16'h0008);
    check("add_flags", flags, 4'b0000);
    cyc();
    check("add_valid_drops", out_valid, 0);
    check("add_result_holds", alu_out, 16'h0008);
    issue(3'd3, 3'd0, 3'b011, 1'b0, 3'd0);
    cyc();
    op_valid = 1'b0;
    cyc();
    check("read_r3", alu_out, 16'h0008);

    // Back-to-back dependent op through forwarding
    issue(3'd1, 3'd2, 3'b000, 1'b1, 3'd4);
    cyc();
    issue(3'd4, 3'd4, 3'b001, 1'b0, 3'd0);
    cyc();
    op_valid = 1'b0;
    check("fwd_op1_result", alu_out, 16'h0008);
    check("fwd_dis_1", dis_1, 4'h8);
    cyc();
    check("fwd_op2_result", alu_out, 16'h0000);
    check("fwd_op2_flags", flags, 4'b0001);
    check("fwd_op2_valid", out_valid, 1);

    // Same pattern without writeback: dependent op sees stale r6=0
    issue(3'd1, 3'd2, 3'b000, 1'b0, 3'd6);
    cyc();
    issue(3'd6, 3'd1, 3'b001, 1'b0, 3'd0);
    cyc();
    op_valid = 1'b0;
    cyc();
    check("stale_result", alu_out, 16'hFFFB);
    check("stale_flags", flags, 4'b1010);

    foreach (vecs[i]) begin
      wr(3'd1, vecs[i].a);
      wr(3'd2, vecs[i].b);
      issue(3'd1, 3'd2, vecs[i].m, 1'b0, 3'd0);
      cyc();
      op_valid = 1'b0;
      cyc();
      check($sformatf("vec%0d_result", i), alu_out, vecs[i].res);
      check($sformatf("vec%0d_flags", i), flags, vecs[i].fl);
    end

    // Writeback and external write to r5 on the same edge
    wr(3'd1, 16'h2222);
    wr(3'd2, 16'h0000);
    issue(3'd1, 3'd2, 3'b000, 1'b1, 3'd5);
    cyc();
    op_valid = 1'b0;
    we = 1'b1; waddr = 3'd5; din = 16'h1111;
    cyc();
    we = 1'b0;
    issue(3'd5, 3'd2, 3'b011, 1'b0, 3'd0);
    cyc();
    op_valid = 1'b0;
    cyc();
    check("collision_r5", alu_out, 16'h2222);

    // Operand bypass from a same-cycle external write
    we = 1'b1; waddr = 3'd5; din = 16'h00AB;
    issue(3'd5, 3'd2, 3'b011, 1'b0, 3'd0);
    cyc();
    we = 1'b0; op_valid = 1'b0;
    check("bypass_dis_1", dis_1, 4'hB);
    cyc();
    check("bypass_result", alu_out, 16'h00AB);

    // WB_ADDR==RA reads the old value; follower forwards the new one
    issue(3'd5, 3'd5, 3'b000, 1'b1, 3'd5);
    cyc();
    issue(3'd5, 3'd2, 3'b011, 1'b0, 3'd0);
    cyc();
    op_valid = 1'b0;
    check("self_wb_result", alu_out, 16'h0156);
    check("self_wb_dis_1", dis_1, 4'h6);
    cyc();
    check("self_wb_fwd", alu_out, 16'h0156);

    // Reset with an op in flight that targets r7; RST also overrides WE
    issue(3'd1, 3'd1, 3'b000, 1'b1, 3'd7);
    cyc();
    op_valid = 1'b0;
    rst = 1'b1; we = 1'b1; waddr = 3'd6; din = 16'hFFFF;
    cyc();
    rst = 1'b0; we = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_alu_out", alu_out, 0);
    check("rst_flags", flags, 0);
    check("rst_dis_1", dis_1, 0);
    check("rst_dis_2", dis_2, 0);
    cyc();
    check("rst_no_late_valid", out_valid, 0);
    issue(3'd7, 3'd6, 3'b011, 1'b0, 3'd0);
    cyc();
    op_valid = 1'b0;
    cyc();
    check("rst_r7_r6_clear", alu_out, 16'h0000);
    check("rst_read_flags", flags, 4'b0001);
    check("rst_read_valid", out_valid, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
